// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: FSM encodings and the packed
// 15-bit time word layout with its per-field limits.
package alarm_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    RINGING   = 3'd3,
    SNOOZE    = 3'd4
  } state_t;

  localparam int unsigned MU_LO = 0;
  localparam int unsigned MU_HI = 3;
  localparam int unsigned MT_LO = 4;
  localparam int unsigned MT_HI = 6;
  localparam int unsigned HR_LO = 7;
  localparam int unsigned HR_HI = 11;
  localparam int unsigned DY_LO = 12;
  localparam int unsigned DY_HI = 14;

  localparam logic [3:0] MU_MAX = 4'd9;
  localparam logic [2:0] MT_MAX = 3'd5;
  localparam logic [4:0] HR_MAX = 5'd23;
  localparam logic [2:0] DY_MAX = 3'd6;

endpackage

// File: rtl/alarm_sequencer_time_word_check.sv
// Combinational range check of a packed time word; also usable by the
// display/entry logic.
module alarm_sequencer_time_word_check
  import alarm_sequencer_pkg::*;
(
  input  logic [14:0] word,
  output logic        valid
);

  assign valid = (word[MU_HI:MU_LO] <= MU_MAX) &&
                 (word[MT_HI:MT_LO] <= MT_MAX) &&
                 (word[HR_HI:HR_LO] <= HR_MAX) &&
                 (word[DY_HI:DY_LO] <= DY_MAX);

endmodule

// File: rtl/alarm_sequencer.sv
// Control FSM for the current-time counter chain: time/alarm entry, alarm
// match, ringing with snooze and auto-off.
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 10
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [14:0] CTO,
  input  logic [14:0] SET_VAL,
  input  logic [6:0]  DAY_EN,
  input  logic        ALARM_ARM,
  input  logic        KEY_TIME_SET,
  input  logic        KEY_ALARM_SET,
  input  logic        KEY_SNOOZE,
  input  logic        KEY_OFF,
  output logic        LD_CT,
  output logic        EN_CT,
  output logic [14:0] CTI,
  output logic [14:0] AT,
  output logic        ALARM_OUT,
  output logic        ERR,
  output logic [2:0]  STATE
);

  localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LOAD   = 4'(RING_MIN);

  state_t     state, state_n;
  logic [3:0] keys, key_q, key_edge;
  logic [3:0] ctq;
  logic       ld_q;
  logic       match, match_q, trigger, tick, any_key;
  logic [7:0] day_mask;
  logic [3:0] ring_cnt, ring_n, snz_cnt, snz_n;
  logic       ld_n, err_n, at_ld;
  logic       set_ok;

  alarm_sequencer_time_word_check u_check (
    .word  (SET_VAL),
    .valid (set_ok)
  );

  assign keys     = {KEY_OFF, KEY_SNOOZE, KEY_ALARM_SET, KEY_TIME_SET};
  assign key_edge = keys & ~key_q;
  assign any_key  = |key_edge;

  // Day 7 is not a valid day; pad the mask so it never matches.
  assign day_mask = {1'b0, DAY_EN};
  assign match    = (CTO[11:0] == AT[11:0]) && day_mask[CTO[DY_HI:DY_LO]] && ALARM_ARM;
  assign trigger  = match && !match_q;

  // The datapath output changes one cycle after a load; that step is not a minute.
  assign tick = (CTO[MU_HI:MU_LO] != ctq) && !ld_q;

  always_comb begin
    state_n = state;
    ring_n  = ring_cnt;
    snz_n   = snz_cnt;
    ld_n    = 1'b0;
    err_n   = 1'b0;
    at_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_n = RINGING;
          ring_n  = RING_LOAD;
        end else if (key_edge[0]) begin
          state_n = SET_TIME;
        end else if (key_edge[1]) begin
          state_n = SET_ALARM;
        end
      end
      SET_TIME: begin
        if (key_edge[0]) begin
          ld_n    = set_ok;
          err_n   = !set_ok;
          state_n = IDLE;
        end else if (key_edge[3]) begin
          state_n = IDLE;
        end
      end
      SET_ALARM: begin
        if (key_edge[1]) begin
          at_ld   = set_ok;
          err_n   = !set_ok;
          state_n = IDLE;
        end else if (key_edge[3]) begin
          state_n = IDLE;
        end
      end
      RINGING: begin
        if (key_edge[3] || !ALARM_ARM) begin
          state_n = IDLE;
        end else if (key_edge[2]) begin
          state_n = SNOOZE;
          snz_n   = SNOOZE_LOAD;
        end else if (tick && !any_key) begin
          if (ring_cnt <= 4'd1) begin
            ring_n  = '0;
            state_n = IDLE;
          end else begin
            ring_n = ring_cnt - 4'd1;
          end
        end
      end
      SNOOZE: begin
        if (key_edge[3] || !ALARM_ARM) begin
          state_n = IDLE;
        end else if (tick && !any_key) begin
          if (snz_cnt <= 4'd1) begin
            snz_n   = '0;
            state_n = RINGING;
            ring_n  = RING_LOAD;
          end else begin
            snz_n = snz_cnt - 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state     <= IDLE;
      key_q     <= '0;
      ctq       <= '0;
      ld_q      <= 1'b0;
      match_q   <= 1'b0;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      LD_CT     <= 1'b0;
      EN_CT     <= 1'b0;
      CTI       <= '0;
      AT        <= '0;
      ALARM_OUT <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_n;
      key_q     <= keys;
      ctq       <= CTO[MU_HI:MU_LO];
      ld_q      <= LD_CT;
      match_q   <= match;
      ring_cnt  <= ring_n;
      snz_cnt   <= snz_n;
      LD_CT     <= ld_n;
      EN_CT     <= (state_n != SET_TIME);
      ALARM_OUT <= (state_n == RINGING);
      ERR       <= err_n;
      if (state == SET_TIME) CTI <= SET_VAL;
      if (at_ld) AT <= SET_VAL;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer.
module tb_alarm_sequencer;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [14:0] CTO, SET_VAL;
  logic [6:0]  DAY_EN;
  logic        ALARM_ARM, KEY_TIME_SET, KEY_ALARM_SET, KEY_SNOOZE, KEY_OFF;
  logic        LD_CT, EN_CT, ALARM_OUT, ERR;
  logic [14:0] CTI, AT;
  logic [2:0]  STATE;

  int checks = 0;
  int errors = 0;

  alarm_sequencer #(.SNOOZE_MIN(5), .RING_MIN(10)) dut (
    .Clk(Clk), .Clr(Clr), .CTO(CTO), .SET_VAL(SET_VAL), .DAY_EN(DAY_EN),
    .ALARM_ARM(ALARM_ARM), .KEY_TIME_SET(KEY_TIME_SET), .KEY_ALARM_SET(KEY_ALARM_SET),
    .KEY_SNOOZE(KEY_SNOOZE), .KEY_OFF(KEY_OFF), .LD_CT(LD_CT), .EN_CT(EN_CT),
    .CTI(CTI), .AT(AT), .ALARM_OUT(ALARM_OUT), .ERR(ERR), .STATE(STATE)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clr = 1'b1; CTO = '0; SET_VAL = '0; DAY_EN = '0; ALARM_ARM = 1'b0;
    KEY_TIME_SET = 1'b0; KEY_ALARM_SET = 1'b0; KEY_SNOOZE = 1'b0; KEY_OFF = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({LD_CT, EN_CT, CTI, AT, ALARM_OUT, ERR, STATE} !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs: got LD=%b EN=%b CTI=%h AT=%h AL=%b ERR=%b ST=%0d expected all 0",
                 LD_CT, EN_CT, CTI, AT, ALARM_OUT, ERR, STATE);
      end
    end
    Clr = 1'b0;
    step();
    checks++;
    if (EN_CT !== 1'b1 || STATE !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: got EN=%b ST=%0d expected EN=1 ST=0", EN_CT, STATE);
    end
  endtask

  task automatic test_set_time();
    SET_VAL = 15'h13B0;
    KEY_TIME_SET = 1'b1; step();
    checks++;
    if (STATE !== 3'd1 || EN_CT !== 1'b0) begin
      errors++;
      $display("FAIL set_time_enter: got ST=%0d EN=%b expected ST=1 EN=0", STATE, EN_CT);
    end
    KEY_TIME_SET = 1'b0; step();
    checks++;
    if (CTI !== 15'h13B0 || LD_CT !== 1'b0 || EN_CT !== 1'b0) begin
      errors++;
      $display("FAIL set_time_follow: got CTI=%h LD=%b EN=%b expected CTI=13b0 LD=0 EN=0", CTI, LD_CT, EN_CT);
    end
    KEY_TIME_SET = 1'b1; step();
    checks++;
    if (LD_CT !== 1'b1 || CTI !== 15'h13B0 || STATE !== 3'd0 || EN_CT !== 1'b1) begin
      errors++;
      $display("FAIL set_time_load: got LD=%b CTI=%h ST=%0d EN=%b expected LD=1 CTI=13b0 ST=0 EN=1",
               LD_CT, CTI, STATE, EN_CT);
    end
    KEY_TIME_SET = 1'b0; CTO = 15'h13B0; step();
    checks++;
    if (LD_CT !== 1'b0 || EN_CT !== 1'b1 || STATE !== 3'd0) begin
      errors++;
      $display("FAIL set_time_strobe_len: got LD=%b EN=%b ST=%0d expected LD=0 EN=1 ST=0", LD_CT, EN_CT, STATE);
    end
  endtask

  task automatic test_invalid_time();
    SET_VAL = 15'h000A;
    KEY_TIME_SET = 1'b1; step();
    KEY_TIME_SET = 1'b0; step();
    KEY_TIME_SET = 1'b1; step();
    checks++;
    if (ERR !== 1'b1 || LD_CT !== 1'b0 || STATE !== 3'd0) begin
      errors++;
      $display("FAIL invalid_time: got ERR=%b LD=%b ST=%0d expected ERR=1 LD=0 ST=0", ERR, LD_CT, STATE);
    end
    KEY_TIME_SET = 1'b0; step();
    checks++;
    if (ERR !== 1'b0 || LD_CT !== 1'b0) begin
      errors++;
      $display("FAIL invalid_time_pulse: got ERR=%b LD=%b expected ERR=0 LD=0", ERR, LD_CT);
    end
  endtask

  task automatic test_set_alarm();
    SET_VAL = 15'h13B0;
    KEY_ALARM_SET = 1'b1; step();
    checks++;
    if (STATE !== 3'd2 || EN_CT !== 1'b1) begin
      errors++;
      $display("FAIL set_alarm_enter: got ST=%0d EN=%b expected ST=2 EN=1", STATE, EN_CT);
    end
    KEY_ALARM_SET = 1'b0; step();
    KEY_ALARM_SET = 1'b1; step();
    checks++;
    if (AT !== 15'h13B0 || STATE !== 3'd0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL set_alarm_store: got AT=%h ST=%0d ERR=%b expected AT=13b0 ST=0 ERR=0", AT, STATE, ERR);
    end
    // hours = 24 is out of range
    KEY_ALARM_SET = 1'b0; SET_VAL = 15'h0C00; step();
    KEY_ALARM_SET = 1'b1; step();
    KEY_ALARM_SET = 1'b0; step();
    KEY_ALARM_SET = 1'b1; step();
    checks++;
    if (ERR !== 1'b1 || AT !== 15'h13B0 || STATE !== 3'd0) begin
      errors++;
      $display("FAIL set_alarm_invalid: got ERR=%b AT=%h ST=%0d expected ERR=1 AT=13b0 ST=0", ERR, AT, STATE);
    end
    KEY_ALARM_SET = 1'b0; step();
  endtask

  task automatic test_ring_snooze();
    DAY_EN = 7'b0000010; ALARM_ARM = 1'b1; CTO = 15'h13A9; step();
    checks++;
    if (ALARM_OUT !== 1'b0 || STATE !== 3'd0) begin
      errors++;
      $display("FAIL ring_premature: got AL=%b ST=%0d expected AL=0 ST=0", ALARM_OUT, STATE);
    end
    CTO = 15'h13B0; step();
    checks++;
    if (ALARM_OUT !== 1'b1 || STATE !== 3'd3) begin
      errors++;
      $display("FAIL ring_start: got AL=%b ST=%0d expected AL=1 ST=3", ALARM_OUT, STATE);
    end
    KEY_SNOOZE = 1'b1; step();
    KEY_SNOOZE = 1'b0;
    checks++;
    if (ALARM_OUT !== 1'b0 || STATE !== 3'd4) begin
      errors++;
      $display("FAIL snooze_enter: got AL=%b ST=%0d expected AL=0 ST=4", ALARM_OUT, STATE);
    end
    for (int i = 1; i <= 5; i++) begin
      CTO = 15'h13B0 | 15'(i);
      step();
      checks++;
      if (i < 5 && (ALARM_OUT !== 1'b0 || STATE !== 3'd4)) begin
        errors++;
        $display("FAIL snooze_tick%0d: got AL=%b ST=%0d expected AL=0 ST=4", i, ALARM_OUT, STATE);
      end else if (i == 5 && (ALARM_OUT !== 1'b1 || STATE !== 3'd3)) begin
        errors++;
        $display("FAIL snooze_rering: got AL=%b ST=%0d expected AL=1 ST=3", ALARM_OUT, STATE);
      end
    end
  endtask

  task automatic test_auto_off();
    for (int i = 0; i < 10; i++) begin
      CTO = 15'h13C0 | 15'((6 + i) % 10);
      step();
      checks++;
      if (i < 9 && (ALARM_OUT !== 1'b1 || STATE !== 3'd3)) begin
        errors++;
        $display("FAIL auto_off_tick%0d: got AL=%b ST=%0d expected AL=1 ST=3", i + 1, ALARM_OUT, STATE);
      end else if (i == 9 && (ALARM_OUT !== 1'b0 || STATE !== 3'd0)) begin
        errors++;
        $display("FAIL auto_off_end: got AL=%b ST=%0d expected AL=0 ST=0", ALARM_OUT, STATE);
      end
    end
  endtask

  task automatic test_key_off();
    CTO = 15'h13A9; step();
    CTO = 15'h13B0; step();
    checks++;
    if (ALARM_OUT !== 1'b1 || STATE !== 3'd3) begin
      errors++;
      $display("FAIL key_off_ring: got AL=%b ST=%0d expected AL=1 ST=3", ALARM_OUT, STATE);
    end
    KEY_OFF = 1'b1; step();
    KEY_OFF = 1'b0;
    checks++;
    if (ALARM_OUT !== 1'b0 || STATE !== 3'd0) begin
      errors++;
      $display("FAIL key_off_stop: got AL=%b ST=%0d expected AL=0 ST=0", ALARM_OUT, STATE);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ALARM_OUT !== 1'b0 || STATE !== 3'd0) begin
        errors++;
        $display("FAIL key_off_no_retrigger%0d: got AL=%b ST=%0d expected AL=0 ST=0", i, ALARM_OUT, STATE);
      end
    end
  endtask

  task automatic test_day_mask();
    CTO = 15'h23A9; step();
    CTO = 15'h23B0; step();
    step();
    checks++;
    if (ALARM_OUT !== 1'b0 || STATE !== 3'd0) begin
      errors++;
      $display("FAIL day_mask: got AL=%b ST=%0d expected AL=0 ST=0", ALARM_OUT, STATE);
    end
  endtask

  task automatic test_load_trigger_and_abort();
    CTO = 15'h0000; step();
    SET_VAL = 15'h13B0;
    KEY_TIME_SET = 1'b1; step();
    KEY_TIME_SET = 1'b0; step();
    KEY_TIME_SET = 1'b1; step();
    KEY_TIME_SET = 1'b0;
    checks++;
    if (LD_CT !== 1'b1 || CTI !== 15'h13B0) begin
      errors++;
      $display("FAIL load_trigger_ld: got LD=%b CTI=%h expected LD=1 CTI=13b0", LD_CT, CTI);
    end
    CTO = 15'h13B0; step();
    checks++;
    if (ALARM_OUT !== 1'b1 || STATE !== 3'd3) begin
      errors++;
      $display("FAIL load_trigger_ring: got AL=%b ST=%0d expected AL=1 ST=3", ALARM_OUT, STATE);
    end
    Clr = 1'b1; step();
    checks++;
    if ({LD_CT, EN_CT, CTI, AT, ALARM_OUT, ERR, STATE} !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid_ring: got LD=%b EN=%b CTI=%h AT=%h AL=%b ERR=%b ST=%0d expected all 0",
               LD_CT, EN_CT, CTI, AT, ALARM_OUT, ERR, STATE);
    end
    Clr = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_invalid_time();
    test_set_alarm();
    test_ring_snooze();
    test_auto_off();
    test_key_off();
    test_day_mask();
    test_load_trigger_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Control FSM that sequences the current-time counter chain: drives its load, enable and load-value inputs; holds the alarm time; compares it against live time; runs ring / snooze / auto-off.
- Sits between the debounced front-panel keys and the current-time datapath.
- Time word format, 15 bits packed:
  - [3:0] minute units, BCD 0-9
  - [6:4] minute tens, 0-5
  - [11:7] hours, binary 0-23
  - [14:12] day, 0-6

Parameters:
- SNOOZE_MIN, 5, minutes spent in SNOOZE before re-ringing (1-15).
- RING_MIN, 10, minutes of continuous ringing before auto-off (1-15).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Clr  input  1  reset, synchronous, active-high.
- CTO  input  15  live time from the current-time datapath.
- SET_VAL  input  15  user-entered time word.
- DAY_EN  input  7  bit d=1 enables the alarm on day d.
- ALARM_ARM  input  1  level; alarm armed.
- KEY_TIME_SET, KEY_ALARM_SET, KEY_SNOOZE, KEY_OFF  input  1 each  debounced, synchronized levels; the block acts on rising edges.
- LD_CT  output  1  one-cycle load strobe to the datapath.
- EN_CT  output  1  count enable to the datapath.
- CTI  output  15  load value to the datapath.
- AT  output  15  stored alarm time.
- ALARM_OUT  output  1  buzzer drive.
- ERR  output  1  one-cycle pulse on a rejected entry.
- STATE  output  3  encoded FSM state, for display.

Behaviour:
- Reset (Clr=1 at edge), all registers and outputs cleared:
  - STATE=IDLE, LD_CT=0, EN_CT=0, CTI=0, AT=0, ALARM_OUT=0, ERR=0.
  - Key-edge, match and tick history registers cleared.
  - Clr wins over every other input. Reset mid-ring or mid-set aborts with no load.
- Key edge: edge = key & ~key_q. Edges are registered every cycle in every state.
- Validity of a word w: w[3:0]<=9, w[6:4]<=5, w[11:7]<=23, w[14:12]<=6.
- Minute tick: CTO[3:0] != ctq[3:0], where ctq is CTO registered. The tick is suppressed in the cycle after LD_CT.
- Match: CTO[11:0]==AT[11:0] && DAY_EN[CTO[14:12]] && ALARM_ARM.
  - Trigger = match & ~match_q, so an alarm fires once per matching minute.
  - A load that lands exactly on the alarm time does trigger.
- States: IDLE=0, SET_TIME=1, SET_ALARM=2, RINGING=3, SNOOZE=4. EN_CT=1 in all states except SET_TIME and reset.
- IDLE:
  - Trigger -> RINGING, ring_cnt=RING_MIN.
  - Else KEY_TIME_SET edge -> SET_TIME.
  - Else KEY_ALARM_SET edge -> SET_ALARM.
  - Priority: trigger > time set > alarm set.
- SET_TIME:
  - EN_CT=0 (datapath frozen); CTI follows SET_VAL combinationally-registered (1-cycle lag).
  - KEY_TIME_SET edge with valid SET_VAL -> LD_CT=1 for exactly one cycle with CTI=SET_VAL, then -> IDLE.
  - KEY_TIME_SET edge with invalid SET_VAL -> ERR pulse, no LD_CT, -> IDLE.
  - KEY_OFF edge -> IDLE, no load.
- SET_ALARM:
  - Counting continues.
  - KEY_ALARM_SET edge with valid SET_VAL: AT<=SET_VAL, -> IDLE.
  - Invalid SET_VAL: ERR, AT unchanged, -> IDLE.
  - KEY_OFF edge -> IDLE.
  - Triggers are ignored while here; match_q still updates.
- RINGING:
  - ALARM_OUT=1 (registered; rises the cycle the state is entered).
  - Priority: KEY_OFF edge or ALARM_ARM=0 -> IDLE > KEY_SNOOZE edge -> SNOOZE with snz_cnt=SNOOZE_MIN > tick.
  - On a tick, ring_cnt decrements; at 0 -> IDLE.
  - Set keys are ignored.
- SNOOZE:
  - ALARM_OUT=0.
  - KEY_OFF edge or ALARM_ARM=0 -> IDLE.
  - On a tick, snz_cnt decrements; at 0 -> RINGING with ring_cnt=RING_MIN.
  - Snooze count is unlimited.
- Counters are 4-bit, saturating at 0.
- A simultaneous tick and key edge in the same cycle: the key takes precedence and the tick is discarded.

Decomposition:
- Shared package holds:
  - state encodings
  - time-field bit positions (MU_LO/HI, MT_LO/HI, HR_LO/HI, DY_LO/HI)
  - field limits 9/5/23/6
- Natural sub-module: time_word_check (combinational validity of a 15-bit word), reused by the display/entry logic.

Test Plan:
- Clr for 2 cycles, then release -> all outputs 0 during reset; EN_CT=1 and STATE=0 the cycle after release.
- Set time to 07:30 day 1 (0x13B0):
  - stimulus: KEY_TIME_SET edge, SET_VAL=0x13B0, second KEY_TIME_SET edge.
  - response: EN_CT=0 in SET_TIME; LD_CT high exactly 1 cycle with CTI=0x13B0; then IDLE, EN_CT=1.
- Set time with invalid entry: SET_VAL=0x000A (minute units 10) -> ERR 1 cycle, no LD_CT, STATE back to 0.
- Ring then snooze:
  - setup: AT=0x13B0, DAY_EN=7'b0000010, ARM=1; CTO steps 0x13A9 -> 0x13B0.
  - response: ALARM_OUT=1 next cycle.
  - KEY_SNOOZE -> ALARM_OUT=0; after 5 minute-unit changes, ALARM_OUT=1 again.
- Day mask: CTO reaches 0x23B0 (day 2) with DAY_EN bit2=0 -> no ring.
- Auto-off and KEY_OFF:
  - ringing with 10 ticks and no key -> IDLE, ALARM_OUT=0.
  - KEY_OFF during ringing -> IDLE next cycle; no retrigger while CTO stays at 0x13B0.
